// File: rtl/hc595_chain_drv.sv
// Serial driver for a chain of 74HC595 shift registers feeding a multiplexed display.
// Shifts one {sel, seg} frame, pulses the storage clock and drives output enable.
module hc595_chain_drv #(
    parameter int SEL_W         = 6,
    parameter int SEG_W         = 8,
    parameter int DIV           = 2,
    parameter int SEG_MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SEL_W-1:0] sel,
    input  logic [SEG_W-1:0] seg,
    input  logic             blank,
    output logic             busy,
    output logic             done,
    output logic             shcp,
    output logic             stcp,
    output logic             ds,
    output logic             oe
);

    localparam int N  = SEL_W + SEG_W;
    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);
    localparam logic [PW-1:0] LAST_PH  = PW'(DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;

    logic [1:0]       r_state;
    logic [N-1:0]     r_frame;
    logic [SEL_W-1:0] r_latSel;
    logic [BW-1:0]    r_bitCnt;
    logic [PW-1:0]    r_phase;
    logic [N-1:0]     w_frameIn;
    logic [BW-1:0]    w_nextIdx;

    // Frame is stored in serial order: bit 0 goes out first.
    always_comb begin
        w_frameIn = '0;
        w_frameIn[SEL_W-1:0] = sel;
        for (int j = 0; j < SEG_W; j++) begin
            w_frameIn[SEL_W+j] = (SEG_MSB_FIRST != 0) ? seg[SEG_W-1-j] : seg[j];
        end
    end

    assign w_nextIdx = r_bitCnt + BW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_frame  <= '0;
            r_latSel <= '0;
            r_bitCnt <= '0;
            r_phase  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            shcp     <= 1'b0;
            stcp     <= 1'b0;
            ds       <= 1'b0;
            oe       <= 1'b1;
        end else begin
            done <= 1'b0;
            oe   <= blank || (r_latSel == '0);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_frame  <= w_frameIn;
                        ds       <= w_frameIn[0];
                        r_state  <= S_SHIFT;
                        busy     <= 1'b1;
                        r_bitCnt <= '0;
                        r_phase  <= '0;
                        shcp     <= 1'b0;
                    end
                end
                // The shcp register doubles as the low/high half-period flag.
                S_SHIFT: begin
                    if (r_phase == LAST_PH) begin
                        r_phase <= '0;
                        if (!shcp) begin
                            shcp <= 1'b1;
                        end else if (r_bitCnt == LAST_BIT) begin
                            shcp     <= 1'b0;
                            stcp     <= 1'b1;
                            r_latSel <= r_frame[SEL_W-1:0];
                            r_state  <= S_LATCH;
                        end else begin
                            shcp     <= 1'b0;
                            r_bitCnt <= w_nextIdx;
                            ds       <= r_frame[w_nextIdx];
                        end
                    end else begin
                        r_phase <= r_phase + PW'(1);
                    end
                end
                S_LATCH: begin
                    if (r_phase == LAST_PH) begin
                        r_phase <= '0;
                        stcp    <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_phase <= r_phase + PW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hc595_chain_drv.sv
// Bench for hc595_chain_drv: default build plus two small builds (DIV=1 LSB-first, DIV=3 MSB-first).
// Table-driven frames followed by hand-written reset, blank and back-to-back sequences.
module tb_hc595_chain_drv;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       startA = 1'b0, blankA = 1'b0;
    logic [5:0] selA = '0;
    logic [7:0] segA = '0;
    logic       busyA, doneA, shcpA, stcpA, dsA, oeA;

    logic       startB = 1'b0, startC = 1'b0, blankS = 1'b0;
    logic [1:0] selS = '0;
    logic [3:0] segS = '0;
    logic       busyB, doneB, shcpB, stcpB, dsB, oeB;
    logic       busyC, doneC, shcpC, stcpC, dsC, oeC;

    int testsRun = 0;
    int testsFailed = 0;
    int probe = 0;
    logic pShcp, pStcp, pDs, pOe, pBusy, pDone;

    typedef struct {
        int         dutId;
        logic [5:0] sel;
        logic [7:0] seg;
        logic       blank;
        logic [0:13] expDs;
        logic       expOe;
    } vecT;

    vecT vecs [6];

    hc595_chain_drv dutA (
        .clk(clk), .rst(rst), .start(startA), .sel(selA), .seg(segA), .blank(blankA),
        .busy(busyA), .done(doneA), .shcp(shcpA), .stcp(stcpA), .ds(dsA), .oe(oeA)
    );

    hc595_chain_drv #(.SEL_W(2), .SEG_W(4), .DIV(1), .SEG_MSB_FIRST(0)) dutB (
        .clk(clk), .rst(rst), .start(startB), .sel(selS), .seg(segS), .blank(blankS),
        .busy(busyB), .done(doneB), .shcp(shcpB), .stcp(stcpB), .ds(dsB), .oe(oeB)
    );

    hc595_chain_drv #(.SEL_W(2), .SEG_W(4), .DIV(3), .SEG_MSB_FIRST(1)) dutC (
        .clk(clk), .rst(rst), .start(startC), .sel(selS), .seg(segS), .blank(blankS),
        .busy(busyC), .done(doneC), .shcp(shcpC), .stcp(stcpC), .ds(dsC), .oe(oeC)
    );

    always #5 clk = ~clk;

    always_comb begin
        {pShcp, pStcp, pDs, pOe, pBusy, pDone} = {shcpA, stcpA, dsA, oeA, busyA, doneA};
        case (probe)
            1: {pShcp, pStcp, pDs, pOe, pBusy, pDone} = {shcpB, stcpB, dsB, oeB, busyB, doneB};
            2: {pShcp, pStcp, pDs, pOe, pBusy, pDone} = {shcpC, stcpC, dsC, oeC, busyC, doneC};
            default: ;
        endcase
    end

    function automatic int divOf(input int id);
        return (id == 0) ? 2 : ((id == 1) ? 1 : 3);
    endfunction

    function automatic int nOf(input int id);
        return (id == 0) ? 14 : 6;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drives one frame request from a negedge; returns at the negedge of cycle T+1.
    task automatic applyStimulus(input vecT v);
        case (v.dutId)
            0: begin selA = v.sel; segA = v.seg; blankA = v.blank; startA = 1'b1; end
            1: begin selS = v.sel[1:0]; segS = v.seg[3:0]; blankS = v.blank; startB = 1'b1; end
            default: begin selS = v.sel[1:0]; segS = v.seg[3:0]; blankS = v.blank; startC = 1'b1; end
        endcase
        @(posedge clk);
        @(negedge clk);
        startA = 1'b0;
        startB = 1'b0;
        startC = 1'b0;
    endtask

    task automatic runVector(input vecT v, input string tag);
        int div, n, nRise, riseErr, stableErr, highCnt, firstStcp, stcpCnt;
        int doneCnt, doneCyc, busyCnt, lastBusy;
        logic prevShcp, prevDs;
        logic [0:13] dsLog;
        div = divOf(v.dutId);
        n = nOf(v.dutId);
        probe = v.dutId;
        {nRise, riseErr, stableErr, highCnt, stcpCnt, doneCnt, busyCnt} = '0;
        firstStcp = -1; doneCyc = -1; lastBusy = -1;
        prevShcp = 1'b0; prevDs = 1'b0; dsLog = '0;
        applyStimulus(v);
        for (int rel = 1; rel <= 2*div*n + div + 6; rel++) begin
            if (pShcp && !prevShcp) begin
                if (nRise < 14) dsLog[nRise] = pDs;
                if (rel != 1 + 2*div*nRise + div) riseErr++;
                if (pDs !== prevDs) stableErr++;
                nRise++;
            end
            if (pShcp) highCnt++;
            if (pStcp) begin
                if (firstStcp < 0) firstStcp = rel;
                stcpCnt++;
            end
            if (pDone) begin doneCnt++; doneCyc = rel; end
            if (pBusy) begin busyCnt++; lastBusy = rel; end
            prevShcp = pShcp;
            prevDs = pDs;
            @(negedge clk);
        end
        checkOutput({tag, " ds_seq"}, 32'(dsLog), 32'(v.expDs));
        checkOutput({tag, " rise_count"}, nRise, n);
        checkOutput({tag, " rise_timing_errs"}, riseErr, 0);
        checkOutput({tag, " ds_stable_errs"}, stableErr, 0);
        checkOutput({tag, " shcp_high_cycles"}, highCnt, div*n);
        checkOutput({tag, " stcp_first"}, firstStcp, 2*div*n + 1);
        checkOutput({tag, " stcp_cycles"}, stcpCnt, div);
        checkOutput({tag, " done_cycle"}, doneCyc, 2*div*n + div + 1);
        checkOutput({tag, " done_count"}, doneCnt, 1);
        checkOutput({tag, " busy_cycles"}, busyCnt, 2*div*n + div);
        checkOutput({tag, " busy_last"}, lastBusy, 2*div*n + div);
        checkOutput({tag, " oe_after"}, pOe, v.expOe);
    endtask

    initial begin
        int nRise, done1, done2, stcpCnt, doneCnt, busyCnt;
        logic prevShcp, busyAt59, busyAt60;
        logic [0:27] btbLog;

        vecs[0] = '{0, 6'b000001, 8'hA5, 1'b0, 14'b10000010100101, 1'b0};
        vecs[1] = '{0, 6'b100110, 8'h3C, 1'b0, 14'b01100100111100, 1'b0};
        vecs[2] = '{0, 6'b000000, 8'hFF, 1'b0, 14'b00000011111111, 1'b1};
        vecs[3] = '{0, 6'b111111, 8'h01, 1'b1, 14'b11111100000001, 1'b1};
        vecs[4] = '{1, 6'b000010, 8'h03, 1'b0, 14'b01110000000000, 1'b0};
        vecs[5] = '{2, 6'b000010, 8'h03, 1'b0, 14'b01001100000000, 1'b0};

        // Reset with start held high must leave the block idle.
        startA = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset shcp", shcpA, 0);
        checkOutput("reset stcp", stcpA, 0);
        checkOutput("reset ds", dsA, 0);
        checkOutput("reset oe", oeA, 1);
        checkOutput("reset busy", busyA, 0);
        checkOutput("reset done", doneA, 0);
        startA = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            runVector(vecs[i], $sformatf("vec%0d", i));
        end

        // Latched select is nonzero and blank is high: oe follows blank one cycle later.
        probe = 0;
        blankA = 1'b0;
        checkOutput("blank_fall oe_same_cycle", oeA, 1);
        @(negedge clk);
        checkOutput("blank_fall oe_next", oeA, 0);
        blankA = 1'b1;
        @(negedge clk);
        checkOutput("blank_rise oe_next", oeA, 1);
        blankA = 1'b0;
        @(negedge clk);

        // start held high, with new data applied mid-frame that must not disturb frame one.
        selA = 6'b000001; segA = 8'hA5; startA = 1'b1;
        @(posedge clk);
        @(negedge clk);
        nRise = 0; done1 = -1; done2 = -1; prevShcp = 1'b0; btbLog = '0;
        busyAt59 = 1'b1; busyAt60 = 1'b0;
        for (int rel = 1; rel <= 125; rel++) begin
            if (shcpA && !prevShcp) begin
                if (nRise < 28) btbLog[nRise] = dsA;
                nRise++;
            end
            if (doneA) begin
                if (done1 < 0) done1 = rel; else done2 = rel;
            end
            if (rel == 59) busyAt59 = busyA;
            if (rel == 60) busyAt60 = busyA;
            prevShcp = shcpA;
            if (rel == 10) begin selA = 6'b100110; segA = 8'h3C; end
            if (rel == 117) startA = 1'b0;
            @(negedge clk);
        end
        checkOutput("btb ds_seq", 32'(btbLog), 32'(28'b1000001010010101100100111100));
        checkOutput("btb rise_count", nRise, 28);
        checkOutput("btb done1", done1, 59);
        checkOutput("btb done2", done2, 118);
        checkOutput("btb busy_idle_gap", busyAt59, 0);
        checkOutput("btb busy_restart", busyAt60, 1);

        // Reset on the 20th SHIFT cycle aborts the frame completely.
        applyStimulus(vecs[1]);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort shcp", shcpA, 0);
        checkOutput("abort stcp", stcpA, 0);
        checkOutput("abort ds", dsA, 0);
        checkOutput("abort oe", oeA, 1);
        checkOutput("abort busy", busyA, 0);
        checkOutput("abort done", doneA, 0);
        rst = 1'b0;
        stcpCnt = 0; doneCnt = 0; busyCnt = 0;
        for (int rel = 0; rel < 70; rel++) begin
            if (stcpA) stcpCnt++;
            if (doneA) doneCnt++;
            if (busyA) busyCnt++;
            @(negedge clk);
        end
        checkOutput("abort stcp_after", stcpCnt, 0);
        checkOutput("abort done_after", doneCnt, 0);
        checkOutput("abort busy_after", busyCnt, 0);
        runVector(vecs[0], "post_abort");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/hc595_chain_drv.md
HC595_CHAIN_DRV -- requirements
Module: hc595_chain_drv

Interface
REQ-001 SHALL have parameter SEL_W, default 6: number of digit-select bits shifted per frame (>=1).
REQ-002 SHALL have parameter SEG_W, default 8: number of segment bits shifted per frame (>=1).
REQ-003 SHALL have parameter DIV, default 2: clk cycles per shcp half-period (>=1).
REQ-004 SHALL have parameter SEG_MSB_FIRST, default 1: 1 = seg shifted MSB first; 0 = seg shifted LSB first.
REQ-005 SHALL have port clk  input  1: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-007 SHALL have port start  input  1: frame request, sampled in IDLE only.
REQ-008 SHALL have port sel  input  SEL_W: digit-select pattern, captured on frame accept.
REQ-009 SHALL have port seg  input  SEG_W: segment pattern, captured on frame accept.
REQ-010 SHALL have port blank  input  1: forces display off.
REQ-011 SHALL have port busy  output  1: high while a frame is in SHIFT or LATCH.
REQ-012 SHALL have port done  output  1: one-cycle pulse at frame completion.
REQ-013 SHALL have port shcp  output  1: 74HC595 shift clock.
REQ-014 SHALL have port stcp  output  1: 74HC595 storage (latch) clock.
REQ-015 SHALL have port ds  output  1: 74HC595 serial data.
REQ-016 SHALL have port oe  output  1: 74HC595 output enable, active-low.

Function
REQ-017 SHALL implement states IDLE, SHIFT, LATCH. All outputs SHALL be registered.
REQ-018 In IDLE, with start=1 at cycle T, SHALL capture sel and seg into an N=SEL_W+SEG_W bit frame register and enter SHIFT at T+1.
REQ-019 Serial order SHALL be sel[0], sel[1] .. sel[SEL_W-1], then seg[SEG_W-1] .. seg[0] if SEG_MSB_FIRST=1, else seg[0] .. seg[SEG_W-1].
REQ-020 Each bit SHALL occupy 2*DIV cycles. ds SHALL change only at the first cycle of a bit period. shcp SHALL be 0 for the first DIV cycles and 1 for the last DIV cycles. The shcp rising edge is therefore DIV cycles after the ds change.
REQ-021 After the high phase of bit N-1, SHALL enter LATCH: shcp=0 and stcp=1 for DIV cycles. ds SHALL hold its last value.
REQ-022 busy SHALL be 1 from T+1 through T+2*DIV*N+DIV inclusive.
REQ-023 At cycle T+2*DIV*N+DIV+1, done SHALL be 1 for exactly one cycle, busy SHALL be 0, and the state SHALL be IDLE.
REQ-024 start while busy=1 SHALL be ignored, and the captured frame SHALL NOT change.
REQ-025 start=1 in the same cycle that done=1 SHALL be accepted, giving back-to-back frames with one IDLE cycle.
REQ-026 stcp SHALL be 1 only in LATCH. shcp SHALL be 0 in IDLE and LATCH.
REQ-027 An internal latched-select register SHALL load the captured sel on the first LATCH cycle.
REQ-028 oe SHALL be 1 when blank=1 or the latched-select register is all zero, and 0 otherwise. It SHALL be updated one cycle after a change of either input.
REQ-029 blank SHALL NOT affect shifting, latching, busy or done.
REQ-030 Bit and phase counters SHALL be sized $clog2(N) and $clog2(DIV) (minimum 1 bit each). Counters SHALL NOT wrap within a frame.

Reset
REQ-031 With rst=1 at a clock edge, SHALL force the state to IDLE and set shcp=0, stcp=0, ds=0, oe=1, busy=0, done=0, with the frame and latched-select registers cleared.
REQ-032 Reset mid-SHIFT or mid-LATCH SHALL abort the frame with no further stcp pulse and no done pulse.
REQ-033 start SHALL be ignored while rst=1. The first frame SHALL be acceptable in the cycle after rst falls.

Verification
REQ-034 Defaults, sel=6'b000001, seg=8'hA5, start pulse at T -> ds sequence 1,0,0,0,0,0,1,0,1,0,0,1,0,1; 14 shcp rising edges; stcp high at T+57..T+58; done at T+59; then oe=0.
REQ-035 SEG_MSB_FIRST=0, SEL_W=2, SEG_W=4, DIV=1, sel=2'b10, seg=4'b0011 -> ds sequence 0,1,1,1,0,0; done at T+14.
REQ-036 start held high continuously -> frames separated by exactly one IDLE cycle; extra start pulses during busy change nothing.
REQ-037 rst asserted at the 20th SHIFT cycle -> next cycle all outputs at reset values; no stcp or done for that frame; the following frame is correct.
REQ-038 sel=0 frame -> oe=1 after latch; blank=1 with sel nonzero latched -> oe=1 next cycle, and oe=0 one cycle after blank falls.
REQ-039 DIV=3 -> shcp low 3 cycles / high 3 cycles per bit; ds stable across each shcp rising edge; stcp high for 3 cycles.
